icache: RTL

Direct-mapped, one-word-block instruction cache between the datapath's instruction fetch port and the memory controller's instruction port. It answers datapath fetches combinationally on a hit. On a miss it runs a blocking fill: it requests the word from the memory controller, holds the request until memory stops waiting, and writes the frame. The datapath keeps `imemaddr` stable and stalls until `ihit`.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/icache.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types, including the instruction cache frame and address views.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX   = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX-1:0]   idx;
        logic [1:0]              bytoff;
    } icachef_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped one-word-block instruction cache with a blocking, non-abortable fill.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
`ifdef ICACHE_PERF_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 30 - IDX;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]       state_q, state_d;
    word_t            miss_addr_q, miss_addr_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [TAG_W-1:0] tag_d  [SETS];
    word_t            data_q [SETS];
    word_t            data_d [SETS];

    logic [IDX-1:0]   idx_s, fill_idx_s;
    logic [TAG_W-1:0] tag_s, fill_tag_s;
    logic             hit_s;
    logic             unused_imemaddr_s;

    assign unused_imemaddr_s = ^imemaddr[1:0];

    // Lookup and memory-side outputs; hits never depend on iwait/iload.
    always_comb begin
        idx_s      = imemaddr[IDX+1:2];
        tag_s      = imemaddr[31:IDX+2];
        fill_idx_s = miss_addr_q[IDX+1:2];
        fill_tag_s = miss_addr_q[31:IDX+2];
        hit_s      = (state_q == IDLE) && imemREN && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
        ihit       = hit_s;
        imemload   = hit_s ? data_q[idx_s] : 32'h0000_0000;
        iREN       = (state_q == FETCH);
        iaddr      = (state_q == FETCH) ? miss_addr_q : 32'h0000_0000;
    end

    // Miss detection and fill sequencing.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (imemREN && !hit_s) begin
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    state_d     = FETCH;
                end else begin
                    state_d     = IDLE;
                end
            end
            FETCH: begin
                if (!iwait) begin
                    valid_d[fill_idx_s] = 1'b1;
                    tag_d[fill_idx_s]   = fill_tag_s;
                    data_d[fill_idx_s]  = iload;
                    state_d             = IDLE;
                end else begin
                    state_d             = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state; reset drops any fill in flight and invalidates every frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'h0000_0000;
            valid_q     <= {SETS{1'b0}};
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data storage, qualified by valid_q.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef ICACHE_PERF_EN
    word_t hit_count_q, hit_count_d;
    word_t miss_count_q, miss_count_d;
    logic  miss_s;

    // Saturating hit/miss counters.
    always_comb begin
        miss_s = (state_q == IDLE) && imemREN && !hit_s;
        if (hit_s && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end else begin
            hit_count_d = hit_count_q;
        end
        if (miss_s && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end else begin
            miss_count_d = miss_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= 32'h0000_0000;
            miss_count_q <= 32'h0000_0000;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
